proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Multi-cycle control unit for the 16-bit simple processor.
- Owns the program counter (PC) and instruction register (IR), and fetches from a synchronous instruction ROM.
- Decodes each instruction and drives the control signals for the data memory, register file and 8-function ALU, so one shared datapath executes one instruction at a time.

Parameters:
- PC_W, 7: PC/instruction-ROM address width (128 words).
- D_AW, 8: data-memory address width; equals IR[11:4].

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr  in  16  instruction ROM read data; valid 1 cycle after PC_addr.
- PC_addr  out  PC_W  instruction ROM address (= PC).
- IR  out  16  current instruction register.
- D_addr  out  D_AW  data memory address.
- D_wr  out  1  data memory write enable.
- RF_s  out  1  RF write-data mux select: 1 = memory read data, 0 = ALU Q.
- RF_W_addr  out  4  RF write address.
- RF_W_en  out  1  RF write enable.
- RF_Ra_addr  out  4  RF read port A address.
- RF_Rb_addr  out  4  RF read port B address.
- ALU_s0  out  3  ALU function select.
- State  out  4  current FSM state, for debug/display.
- Halted  out  1  high while in HALT.

Behaviour:
- Reset (async, any state, mid-instruction included):
  - State=INIT, PC=0, IR=0.
  - All enables (D_wr, RF_W_en) =0, RF_s=0, ALU_s0=0, all addresses 0, Halted=0.
  - No write pulse may be issued while Reset is high.
- State encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ALU_OP=7, HALT=8.
- Transitions:
  - INIT -> FETCH (1 cycle).
  - FETCH -> DECODE.
  - DECODE: IR<=Instr, PC<=PC+1; next state chosen from Instr[15:12]:
    - 0000 -> NOOP
    - 0001 -> LOAD_A
    - 0010 -> STORE
    - 0011..1001 -> ALU_OP
    - 1111 -> HALT
    - any other opcode -> NOOP (illegal opcodes are silent no-ops).
  - LOAD_A -> LOAD_B.
  - NOOP, LOAD_B, STORE, ALU_OP -> FETCH.
  - HALT -> HALT until Reset.
- Instruction formats (fields taken from IR):
  - LOAD: d=IR[11:4], w=IR[3:0]; RF[w]=D[d].
  - STORE: d=IR[11:4], a=IR[3:0]; D[d]=RF[a].
  - ALU ops: a=IR[11:8], b=IR[7:4], w=IR[3:0]; RF[w]=f(RF[a],RF[b]).
- Opcode to ALU_s0 mapping:
  - 0011 ADD -> 1
  - 0100 SUB -> 2
  - 0101 MOV -> 3 (pass A)
  - 0110 XOR -> 4
  - 0111 OR -> 5
  - 1000 AND -> 6
  - 1001 INC -> 7
- Outputs are Moore: decoded combinationally from State and IR only, never directly from Instr. Default for every output is 0.
  - LOAD_A: D_addr=d.
  - LOAD_B: D_addr=d, RF_s=1, RF_W_addr=w, RF_W_en=1.
  - STORE: D_addr=d, RF_Ra_addr=a, D_wr=1.
  - ALU_OP: RF_Ra_addr=a, RF_Rb_addr=b, ALU_s0=map(op), RF_s=0, RF_W_addr=w, RF_W_en=1.
- Enables are exactly one cycle wide per instruction.
- Latency: NOOP/STORE/ALU instructions take 3 cycles (FETCH, DECODE, EXEC); LOAD takes 4.
- PC:
  - Increments only in DECODE.
  - Wraps 2^PC_W-1 -> 0 with no flag.
  - Held in HALT; HALT never increments PC further.
- PC_addr=PC at all times; the ROM output sampled in DECODE corresponds to PC as driven during FETCH.

Test Plan:
- Reset then release -> INIT for 1 cycle, FETCH with PC_addr=0; assert Reset during STORE -> D_wr drops immediately, State=0, PC=0.
- ROM[0]=16'h1053 (LOAD d=0x05 w=3), D[5]=16'h00A7 -> LOAD_A then LOAD_B with RF_s=1, RF_W_addr=3, RF_W_en=1 for one cycle; next FETCH has PC_addr=1.
- ROM[1]=16'h3124 (ADD a=1 b=2 w=4) -> ALU_OP: Ra=1, Rb=2, ALU_s0=1, RF_W_addr=4, RF_W_en=1; with RF1=3, RF2=4, RF4=7 afterwards.
- Sweep opcodes 0011..1001 -> ALU_s0 = 1..7 in order; opcode 1010 -> NOOP state, no enables asserted, PC advances.
- ROM[2]=16'h2404 (STORE d=0x40 a=4) -> D_addr=0x40, Ra=4, D_wr=1 for exactly one cycle; then ROM[3]=16'hF000 -> HALT, Halted=1, PC stays 4 for 20+ cycles.
- PC_W=2, ROM all 0000 -> PC_addr sequence 0,1,2,3,0, each NOOP taking 3 cycles.

Source files
------------

// File: rtl/proc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : proc_control_unit
//  Purpose  : Multi-cycle control unit for the 16-bit simple processor.
//             Holds the program counter and instruction register, fetches
//             from a synchronous instruction ROM, decodes each instruction,
//             and drives the data-memory, register-file and ALU controls of
//             a shared datapath, one instruction at a time.
//  Ports    : Clk         - system clock, rising edge
//             Reset       - asynchronous active-high reset
//             Instr       - instruction ROM read data (1-cycle latency)
//             PC_addr     - instruction ROM address (= PC)
//             IR          - current instruction register
//             D_addr      - data memory address
//             D_wr        - data memory write enable
//             RF_s        - RF write mux select (1 = memory, 0 = ALU)
//             RF_W_addr   - RF write address
//             RF_W_en     - RF write enable
//             RF_Ra_addr  - RF read port A address
//             RF_Rb_addr  - RF read port B address
//             ALU_s0      - ALU function select
//             State       - current FSM state (debug)
//             Halted      - high while in HALT
//  Revision : 1.0 - initial release
// ============================================================================
module proc_control_unit #(
   parameter int PC_W = 7,
   parameter int D_AW = 8
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [15:0]     Instr,
   output logic [PC_W-1:0] PC_addr,
   output logic [15:0]     IR,
   output logic [D_AW-1:0] D_addr,
   output logic            D_wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_addr,
   output logic [3:0]      RF_Rb_addr,
   output logic [2:0]      ALU_s0,
   output logic [3:0]      State,
   output logic            Halted
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ALU_OP = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          r_state;
   state_t          w_next_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;

   // ------------------------------------------------------------------
   // State, PC and IR registers. IR and PC only change on leaving DECODE,
   // where the ROM word addressed during FETCH is present on Instr.
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_INIT;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) begin
            r_ir <= Instr;
            r_pc <= r_pc + C_PC_ONE;   // wraps silently at 2^PC_W
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. The opcode is taken straight from Instr in DECODE
   // because IR is only loaded at the end of that cycle.
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_INIT:   w_next_state = S_FETCH;
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: begin
            case (Instr[15:12])
               4'b0000: w_next_state = S_NOOP;
               4'b0001: w_next_state = S_LOAD_A;
               4'b0010: w_next_state = S_STORE;
               4'b0011, 4'b0100, 4'b0101, 4'b0110,
               4'b0111, 4'b1000, 4'b1001:
                        w_next_state = S_ALU_OP;
               4'b1111: w_next_state = S_HALT;
               default: w_next_state = S_NOOP;  // illegal opcode: silent no-op
            endcase
         end
         S_LOAD_A: w_next_state = S_LOAD_B;
         S_NOOP,
         S_LOAD_B,
         S_STORE,
         S_ALU_OP: w_next_state = S_FETCH;
         S_HALT:   w_next_state = S_HALT;
         default:  w_next_state = S_INIT;
      endcase
   end

   // ------------------------------------------------------------------
   // Moore outputs: decoded from the state and IR only, so every enable
   // is exactly one state (one cycle) wide and drops as soon as the
   // asynchronous reset forces the state back to INIT.
   // ------------------------------------------------------------------
   always_comb begin
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = '0;
      case (r_state)
         S_LOAD_A: begin
            D_addr = D_AW'(r_ir[11:4]);
         end
         S_LOAD_B: begin
            D_addr    = D_AW'(r_ir[11:4]);
            RF_s      = 1'b1;
            RF_W_addr = r_ir[3:0];
            RF_W_en   = 1'b1;
         end
         S_STORE: begin
            D_addr     = D_AW'(r_ir[11:4]);
            RF_Ra_addr = r_ir[3:0];
            D_wr       = 1'b1;
         end
         S_ALU_OP: begin
            RF_Ra_addr = r_ir[11:8];
            RF_Rb_addr = r_ir[7:4];
            RF_W_addr  = r_ir[3:0];
            RF_W_en    = 1'b1;
            case (r_ir[15:12])
               4'b0011: ALU_s0 = 3'd1;   // ADD
               4'b0100: ALU_s0 = 3'd2;   // SUB
               4'b0101: ALU_s0 = 3'd3;   // MOV (pass A)
               4'b0110: ALU_s0 = 3'd4;   // XOR
               4'b0111: ALU_s0 = 3'd5;   // OR
               4'b1000: ALU_s0 = 3'd6;   // AND
               4'b1001: ALU_s0 = 3'd7;   // INC
               default: ALU_s0 = 3'd0;
            endcase
         end
         default: ;
      endcase
   end

   assign PC_addr = r_pc;
   assign IR      = r_ir;
   assign State   = r_state;
   assign Halted  = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_proc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_control_unit
//  Purpose  : Self-checking bench for proc_control_unit. A synchronous ROM
//             and a behavioural register file / data memory / ALU surround
//             the DUT; per-cycle expected control outputs are queued when
//             a program is loaded and popped as the DUT steps through it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_control_unit;

   typedef struct packed {
      logic [3:0]  st;
      logic [6:0]  pc;
      logic [15:0] ir;
      logic [7:0]  daddr;
      logic        dwr;
      logic        rfs;
      logic [3:0]  wa;
      logic        wen;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  alu;
      logic        halted;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instr;
   logic [15:0] instr_s;

   logic [6:0]  pc_addr;
   logic [15:0] ir;
   logic [7:0]  d_addr;
   logic        d_wr, rf_s, rf_w_en, halted;
   logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
   logic [2:0]  alu_s0;

   logic [1:0]  s_pc_addr;
   logic [15:0] s_ir;
   logic [7:0]  s_d_addr;
   logic        s_d_wr, s_rf_s, s_rf_w_en, s_halted;
   logic [3:0]  s_rf_w_addr, s_rf_ra_addr, s_rf_rb_addr, s_state;
   logic [2:0]  s_alu_s0;

   logic [15:0] rom  [0:127];
   logic [15:0] rf   [0:15];
   logic [15:0] dmem [0:255];

   exp_t        act;
   exp_t        sbq[$];
   logic [5:0]  sbq_s[$];
   logic [6:0]  m_pc;
   logic [15:0] m_ir;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   proc_control_unit #(.PC_W(7), .D_AW(8)) dut (
      .Clk(clk), .Reset(rst), .Instr(instr),
      .PC_addr(pc_addr), .IR(ir), .D_addr(d_addr), .D_wr(d_wr),
      .RF_s(rf_s), .RF_W_addr(rf_w_addr), .RF_W_en(rf_w_en),
      .RF_Ra_addr(rf_ra_addr), .RF_Rb_addr(rf_rb_addr),
      .ALU_s0(alu_s0), .State(state), .Halted(halted)
   );

   // Second instance with a 4-word program space, fed an all-zero ROM.
   proc_control_unit #(.PC_W(2), .D_AW(8)) dut_small (
      .Clk(clk), .Reset(rst), .Instr(instr_s),
      .PC_addr(s_pc_addr), .IR(s_ir), .D_addr(s_d_addr), .D_wr(s_d_wr),
      .RF_s(s_rf_s), .RF_W_addr(s_rf_w_addr), .RF_W_en(s_rf_w_en),
      .RF_Ra_addr(s_rf_ra_addr), .RF_Rb_addr(s_rf_rb_addr),
      .ALU_s0(s_alu_s0), .State(s_state), .Halted(s_halted)
   );

   assign act = {state, pc_addr, ir, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
                 rf_ra_addr, rf_rb_addr, alu_s0, halted};

   // Synchronous instruction ROMs
   always @(posedge clk) instr   <= rom[pc_addr];
   always @(posedge clk) instr_s <= 16'h0000;

   function automatic logic [15:0] alu_f(input logic [2:0] s,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
      case (s)
         3'd1: alu_f = a + b;
         3'd2: alu_f = a - b;
         3'd3: alu_f = a;
         3'd4: alu_f = a ^ b;
         3'd5: alu_f = a | b;
         3'd6: alu_f = a & b;
         3'd7: alu_f = a + 16'd1;
         default: alu_f = 16'h0000;
      endcase
   endfunction

   // Behavioural datapath driven by the DUT's control outputs
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
         for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
         rf[1]   <= 16'h0003;
         rf[2]   <= 16'h0004;
         dmem[5] <= 16'h00A7;
      end else begin
         if (d_wr) dmem[d_addr] <= rf[rf_ra_addr];
         if (rf_w_en)
            rf[rf_w_addr] <= rf_s ? dmem[d_addr]
                                  : alu_f(alu_s0, rf[rf_ra_addr], rf[rf_rb_addr]);
      end
   end

   function automatic exp_t mk(input logic [3:0] st, input logic [6:0] pc,
                               input logic [15:0] irv);
      exp_t e;
      e        = '0;
      e.st     = st;
      e.pc     = pc;
      e.ir     = irv;
      e.halted = (st == 4'd8);
      return e;
   endfunction

   // Expected per-cycle records for one instruction, from the ISA definition
   task automatic push_instr(input logic [15:0] ins);
      exp_t e;
      sbq.push_back(mk(4'd1, m_pc, m_ir));
      sbq.push_back(mk(4'd2, m_pc, m_ir));
      m_ir = ins;
      m_pc = m_pc + 7'd1;
      case (ins[15:12])
         4'h1: begin
            e = mk(4'd4, m_pc, m_ir); e.daddr = ins[11:4];
            sbq.push_back(e);
            e = mk(4'd5, m_pc, m_ir); e.daddr = ins[11:4];
            e.rfs = 1'b1; e.wa = ins[3:0]; e.wen = 1'b1;
            sbq.push_back(e);
         end
         4'h2: begin
            e = mk(4'd6, m_pc, m_ir); e.daddr = ins[11:4];
            e.ra = ins[3:0]; e.dwr = 1'b1;
            sbq.push_back(e);
         end
         4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            e = mk(4'd7, m_pc, m_ir);
            e.ra = ins[11:8]; e.rb = ins[7:4]; e.wa = ins[3:0]; e.wen = 1'b1;
            e.alu = 3'(ins[15:12] - 4'd2);
            sbq.push_back(e);
         end
         4'hF: sbq.push_back(mk(4'd8, m_pc, m_ir));
         default: sbq.push_back(mk(4'd3, m_pc, m_ir));
      endcase
   endtask

   task automatic push_halt(input int n);
      for (int i = 0; i < n; i++) sbq.push_back(mk(4'd8, m_pc, m_ir));
   endtask

   // Leaves the bench on the falling edge right after reset release (INIT)
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_pc = '0;
      m_ir = '0;
      sbq.delete();
      sbq_s.delete();
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
   endtask

   task automatic test_reset();
      exp_t e;
      clear_rom();
      do_reset();
      sbq.push_back(mk(4'd0, 7'd0, 16'h0000));
      sbq.push_back(mk(4'd1, 7'd0, 16'h0000));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL reset_seq: actual=%h expected=%h", act, e);
         end
         if (sbq.size() > 0) @(negedge clk);
      end
   endtask

   task automatic test_program();
      exp_t e;
      clear_rom();
      rom[0] = 16'h1053;   // LOAD  RF3 = D[0x05]
      rom[1] = 16'h3124;   // ADD   RF4 = RF1 + RF2
      rom[2] = 16'h2404;   // STORE D[0x40] = RF4
      rom[3] = 16'hF000;   // HALT
      do_reset();
      sbq.push_back(mk(4'd0, 7'd0, 16'h0000));
      push_instr(rom[0]);
      push_instr(rom[1]);
      push_instr(rom[2]);
      push_instr(rom[3]);
      push_halt(22);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL program_seq: actual=%h expected=%h", act, e);
         end
         if (sbq.size() > 0) @(negedge clk);
      end
      vectors++;
      if (rf[3] !== 16'h00A7) begin
         miscompares++;
         $display("FAIL load_rf3: actual=%h expected=%h", rf[3], 16'h00A7);
      end
      vectors++;
      if (rf[4] !== 16'h0007) begin
         miscompares++;
         $display("FAIL add_rf4: actual=%h expected=%h", rf[4], 16'h0007);
      end
      vectors++;
      if (dmem[8'h40] !== 16'h0007) begin
         miscompares++;
         $display("FAIL store_d40: actual=%h expected=%h", dmem[8'h40], 16'h0007);
      end
   endtask

   task automatic test_alu_sweep();
      exp_t e;
      clear_rom();
      for (int i = 0; i < 7; i++)
         rom[i] = {4'(i + 3), 4'h1, 4'h2, 4'(i + 5)};
      rom[7] = 16'hA123;   // illegal opcode
      rom[8] = 16'hF000;
      do_reset();
      sbq.push_back(mk(4'd0, 7'd0, 16'h0000));
      for (int i = 0; i < 9; i++) push_instr(rom[i]);
      push_halt(2);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL alu_sweep: actual=%h expected=%h", act, e);
         end
         if (sbq.size() > 0) @(negedge clk);
      end
      vectors++;
      if (rf[5] !== 16'h0007) begin
         miscompares++;
         $display("FAIL sweep_add: actual=%h expected=%h", rf[5], 16'h0007);
      end
      vectors++;
      if (rf[6] !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sweep_sub: actual=%h expected=%h", rf[6], 16'hFFFF);
      end
      vectors++;
      if (rf[11] !== 16'h0004) begin
         miscompares++;
         $display("FAIL sweep_inc: actual=%h expected=%h", rf[11], 16'h0004);
      end
   endtask

   task automatic test_reset_mid_store();
      exp_t e;
      clear_rom();
      rom[0] = 16'h2404;
      do_reset();
      sbq.push_back(mk(4'd0, 7'd0, 16'h0000));
      push_instr(rom[0]);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL store_seq: actual=%h expected=%h", act, e);
         end
         if (sbq.size() > 0) @(negedge clk);
      end
      // Now in STORE with D_wr high; reset must clear everything at once
      #2 rst = 1'b1;
      #1;
      e = mk(4'd0, 7'd0, 16'h0000);
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL async_reset: actual=%h expected=%h", act, e);
      end
   endtask

   task automatic test_pc_wrap();
      logic [5:0] es;
      logic [1:0] p;
      do_reset();
      sbq_s.push_back({4'd0, 2'd0});
      p = 2'd0;
      for (int k = 0; k < 5; k++) begin
         sbq_s.push_back({4'd1, p});
         sbq_s.push_back({4'd2, p});
         p = p + 2'd1;
         sbq_s.push_back({4'd3, p});
      end
      while (sbq_s.size() > 0) begin
         es = sbq_s.pop_front();
         vectors++;
         if ({s_state, s_pc_addr} !== es) begin
            miscompares++;
            $display("FAIL pc_wrap: actual=%h expected=%h", {s_state, s_pc_addr}, es);
         end
         if (sbq_s.size() > 0) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_alu_sweep();
      test_reset_mid_store();
      test_pc_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
